// File: rtl/cmu_pkg.sv
// Shared constants and state encoding for the two-way cache management unit.
package cmu_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WAYS       = 2;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned WORD_OFF_W = 2;
  localparam int unsigned LINE_OFF_W = BYTE_OFF_W + WORD_OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BACK = 2'd1,
    FILL = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/cmu_way.sv
// One cache way: tag, valid, dirty and data storage for every set.
// Data and tag arrays are not reset; valid/dirty clear asynchronously.
module cmu_way
  import cmu_pkg::*;
#(
  parameter int unsigned SETS  = 64,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [WORD_OFF_W-1:0] rd_word,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WORD_OFF_W-1:0] wr_word,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strb,
  input  logic                  set_dirty,
  input  logic                  fill_done,
  input  logic [TAG_W-1:0]      fill_tag
);

  logic [31:0]      data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_word}];

  // Byte-masked word write (store hit or refill word).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_strb[b]) data_mem[{wr_idx, wr_word}][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Tag is committed only once the whole line has arrived.
  always_ff @(posedge clk) begin
    if (fill_done) tag_mem[wr_idx] <= fill_tag;
  end

  // Line status bits; a completed refill leaves the line clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_done) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= 1'b0;
    end else if (set_dirty) begin
      dirty[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/cmu.sv
// Two-way set-associative write-back cache controller with LRU replacement.
// Optional macro CMU_PERF_CNT_EN adds hit_cnt/miss_cnt outputs.
module cmu
  import cmu_pkg::*;
#(
  parameter int unsigned SETS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_r,
  input  logic        en_w,
  input  logic [31:0] addr_rw,
  input  logic [31:0] data_w,
  input  logic [3:0]  wstrb,
  output logic [31:0] data_r,
  output logic        cmu_stall,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
`ifdef CMU_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - LINE_OFF_W - IDX_W;

  state_t                  state;
  logic [WORD_OFF_W-1:0]   ctr;
  logic [IDX_W-1:0]        miss_idx;
  logic [TAG_W-1:0]        miss_tag;
  logic                    vict_way;
  logic [SETS-1:0]         lru;

  logic                    req;
  logic [WORD_OFF_W-1:0]   req_word;
  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    unused_addr_bits;

  logic [IDX_W-1:0]        rd_idx;
  logic [WORD_OFF_W-1:0]   rd_word;
  logic [TAG_W-1:0]        way_tag   [WAYS];
  logic                    way_valid [WAYS];
  logic                    way_dirty [WAYS];
  logic [31:0]             way_data  [WAYS];

  logic                    hit0, hit1, hit, hit_way;
  logic                    lookup_hit, lookup_miss, store_hit;
  logic                    victim, vict_dirty;
  logic                    fill_wr, fill_last;

  logic [IDX_W-1:0]        wr_idx;
  logic [WORD_OFF_W-1:0]   wr_word;
  logic [31:0]             wr_data;
  logic [3:0]              wr_strb;
  logic                    way_wr_en [WAYS];
  logic                    way_set_dirty [WAYS];
  logic                    way_fill_done [WAYS];

  assign req              = en_r | en_w;
  assign req_word         = addr_rw[BYTE_OFF_W +: WORD_OFF_W];
  assign req_idx          = addr_rw[LINE_OFF_W +: IDX_W];
  assign req_tag          = addr_rw[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^addr_rw[BYTE_OFF_W-1:0];

  // The arrays follow the live request in IDLE and the latched miss line otherwise.
  assign rd_idx  = (state == IDLE) ? req_idx  : miss_idx;
  assign rd_word = (state == IDLE) ? req_word : ctr;

  assign hit0        = way_valid[0] && (way_tag[0] == req_tag);
  assign hit1        = way_valid[1] && (way_tag[1] == req_tag);
  assign hit         = hit0 | hit1;
  assign hit_way     = hit1;
  assign lookup_hit  = (state == IDLE) && req && hit;
  assign lookup_miss = (state == IDLE) && req && !hit;
  assign store_hit   = lookup_hit && en_w;
  assign fill_wr     = (state == FILL) && mem_ack_i;
  assign fill_last   = fill_wr && (ctr == 2'd3);

  assign data_r     = hit_way ? way_data[1] : way_data[0];
  assign cmu_stall  = lookup_miss || (state != IDLE);
  assign mem_addr_o = {(state == BACK) ? way_tag[vict_way] : miss_tag, miss_idx, ctr, 2'b00};
  assign mem_data_o = way_data[vict_way];

  // Victim choice: first invalid way, otherwise the LRU way.
  always_comb begin
    victim = 1'b0;
    if (!way_valid[0])      victim = 1'b0;
    else if (!way_valid[1]) victim = 1'b1;
    else                    victim = lru[req_idx];
    vict_dirty = victim ? way_dirty[1] : way_dirty[0];
  end

  // Shared write port: store hits in IDLE, refill words in FILL.
  always_comb begin
    wr_idx  = store_hit ? req_idx  : miss_idx;
    wr_word = store_hit ? req_word : ctr;
    wr_data = store_hit ? data_w   : mem_data_i;
    wr_strb = store_hit ? wstrb    : 4'hF;
    way_wr_en[0]     = (store_hit && !hit_way) || (fill_wr && !vict_way);
    way_wr_en[1]     = (store_hit &&  hit_way) || (fill_wr &&  vict_way);
    way_set_dirty[0] = store_hit && !hit_way;
    way_set_dirty[1] = store_hit &&  hit_way;
    way_fill_done[0] = fill_last && !vict_way;
    way_fill_done[1] = fill_last &&  vict_way;
  end

  cmu_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst(rst),
    .rd_idx(rd_idx), .rd_word(rd_word),
    .rd_tag(way_tag[0]), .rd_valid(way_valid[0]), .rd_dirty(way_dirty[0]), .rd_data(way_data[0]),
    .wr_en(way_wr_en[0]), .wr_idx(wr_idx), .wr_word(wr_word), .wr_data(wr_data), .wr_strb(wr_strb),
    .set_dirty(way_set_dirty[0]), .fill_done(way_fill_done[0]), .fill_tag(miss_tag)
  );

  cmu_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst(rst),
    .rd_idx(rd_idx), .rd_word(rd_word),
    .rd_tag(way_tag[1]), .rd_valid(way_valid[1]), .rd_dirty(way_dirty[1]), .rd_data(way_data[1]),
    .wr_en(way_wr_en[1]), .wr_idx(wr_idx), .wr_word(wr_word), .wr_data(wr_data), .wr_strb(wr_strb),
    .set_dirty(way_set_dirty[1]), .fill_done(way_fill_done[1]), .fill_tag(miss_tag)
  );

  // LRU bit names the way to evict next: the one not just touched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru <= '0;
    end else if (lookup_hit) begin
      lru[req_idx] <= ~hit_way;
    end else if (fill_last) begin
      lru[miss_idx] <= ~vict_way;
    end
  end

  // Miss handling: optional write-back, line refill, one replay cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ctr      <= '0;
      mem_cs_o <= 1'b0;
      mem_we_o <= 1'b0;
      miss_idx <= '0;
      miss_tag <= '0;
      vict_way <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lookup_miss) begin
            miss_idx <= req_idx;
            miss_tag <= req_tag;
            vict_way <= victim;
            ctr      <= '0;
            mem_cs_o <= 1'b1;
            mem_we_o <= vict_dirty;
            state    <= vict_dirty ? BACK : FILL;
          end
        end
        BACK: begin
          if (mem_ack_i) begin
            ctr <= ctr + 2'd1;
            if (ctr == 2'd3) begin
              mem_we_o <= 1'b0;
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ack_i) begin
            ctr <= ctr + 2'd1;
            if (ctr == 2'd3) begin
              mem_cs_o <= 1'b0;
              state    <= WAIT;
            end
          end
        end
        WAIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMU_PERF_CNT_EN
  logic replay;

  // Per-request counters; the post-refill replay hit is not a second request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      replay <= (state == WAIT);
      if (lookup_hit && !replay) hit_cnt  <= hit_cnt + 32'd1;
      if (lookup_miss)           miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
